// File: rtl/sa_ctrl.sv
// sa_ctrl -- sequencing controller for a PE_SIZE x PE_SIZE systolic array.
//
// One tile runs as LOAD_W (weight preload, PE_SIZE cycles), STREAM (ifmap
// streaming, len cycles), DRAIN (2*PE_SIZE cycles for the skewed wavefront
// to leave the array), then a single DONE cycle that pulses done_o.
// The block carries no data: it only drives buffer read strobes/addresses
// and the array's enable lanes.
//
// Optional feature: define SA_CTRL_PERF_EN to add perf_cycles_o, the number
// of busy cycles of the last completed tile.

module sa_ctrl #(
    parameter int PE_SIZE    = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [LEN_WIDTH-1:0]  ifmap_len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  weight_rd_en_o,
    output logic [ADDR_WIDTH-1:0] weight_rd_addr_o,
    output logic                  ifmap_rd_en_o,
    output logic [ADDR_WIDTH-1:0] ifmap_rd_addr_o,
`ifdef SA_CTRL_PERF_EN
    output logic [31:0]           perf_cycles_o,
`endif
    output logic [PE_SIZE-1:0]    weight_en_col_o,
    output logic [PE_SIZE-1:0]    ifmap_en_row_o,
    output logic [PE_SIZE-1:0]    psum_en_row_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // Drain counter only needs to reach 2*PE_SIZE-1.
    localparam int                    DRAIN_W    = $clog2(2 * PE_SIZE);
    localparam logic [DRAIN_W-1:0]    DRAIN_LAST = DRAIN_W'(2 * PE_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] W_LAST     = ADDR_WIDTH'(PE_SIZE - 1);
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE    = LEN_WIDTH'(1);

    state_e                  state_q;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [DRAIN_W-1:0]      drain_cnt_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    weight_rd_en_q;
    logic [ADDR_WIDTH-1:0]   weight_rd_addr_q;
    logic                    ifmap_rd_en_q;
    logic [ADDR_WIDTH-1:0]   ifmap_rd_addr_q;

    // Array-side delay line: weight enable lags the read strobe by one
    // cycle; skew_q[k] is the ifmap read strobe delayed by 1+k cycles.
    logic                    weight_en_q;
    logic [PE_SIZE-1:0]      skew_q;
    logic [PE_SIZE-1:0]      skew_d;
    logic [PE_SIZE-1:0]      row_en;

    // Last ifmap address of the tile; only consulted in STREAM, where
    // len_q is known to be non-zero.
    logic [ADDR_WIDTH-1:0]   len_last;
    assign len_last = ADDR_WIDTH'(len_q - LEN_ONE);

    // Tile sequencer: state plus every registered strobe/address output.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is written with <= so every register in this block
        // sees pre-edge values regardless of statement order.
        if (rst) begin
            state_q          <= ST_IDLE;
            len_q            <= '0;
            drain_cnt_q      <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            weight_rd_en_q   <= 1'b0;
            weight_rd_addr_q <= '0;
            ifmap_rd_en_q    <= 1'b0;
            ifmap_rd_addr_q  <= '0;
        end else if (abort_i) begin
            // Abort beats everything, including a same-cycle start.
            state_q          <= ST_IDLE;
            drain_cnt_q      <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            weight_rd_en_q   <= 1'b0;
            weight_rd_addr_q <= '0;
            ifmap_rd_en_q    <= 1'b0;
            ifmap_rd_addr_q  <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        len_q            <= ifmap_len_i;
                        state_q          <= ST_LOAD_W;
                        busy_q           <= 1'b1;
                        weight_rd_en_q   <= 1'b1;
                        weight_rd_addr_q <= '0;
                    end
                end

                ST_LOAD_W: begin
                    if (weight_rd_addr_q == W_LAST) begin
                        weight_rd_en_q   <= 1'b0;
                        weight_rd_addr_q <= '0;
                        if (len_q != '0) begin
                            state_q         <= ST_STREAM;
                            ifmap_rd_en_q   <= 1'b1;
                            ifmap_rd_addr_q <= '0;
                        end else begin
                            // Nothing to stream and nothing in flight.
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        weight_rd_addr_q <= weight_rd_addr_q + 1'b1;
                    end
                end

                ST_STREAM: begin
                    if (ifmap_rd_addr_q == len_last) begin
                        state_q         <= ST_DRAIN;
                        ifmap_rd_en_q   <= 1'b0;
                        ifmap_rd_addr_q <= '0;
                        drain_cnt_q     <= '0;
                    end else begin
                        ifmap_rd_addr_q <= ifmap_rd_addr_q + 1'b1;
                    end
                end

                ST_DRAIN: begin
                    if (drain_cnt_q == DRAIN_LAST) begin
                        state_q     <= ST_DONE;
                        done_q      <= 1'b1;
                        drain_cnt_q <= '0;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 1'b1;
                    end
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q          <= ST_IDLE;
                    busy_q           <= 1'b0;
                    done_q           <= 1'b0;
                    weight_rd_en_q   <= 1'b0;
                    weight_rd_addr_q <= '0;
                    ifmap_rd_en_q    <= 1'b0;
                    ifmap_rd_addr_q  <= '0;
                end
            endcase
        end
    end

    // Next skew value and lane-reversed view of the skew register.
    always_comb begin
        // NOTE: defaults first so no path through the block leaves a bit
        // unassigned, which would otherwise infer a latch.
        skew_d = '0;
        row_en = '0;
        skew_d[0] = ifmap_rd_en_q;
        for (int k = 1; k < PE_SIZE; k++) begin
            skew_d[k] = skew_q[k-1];
        end
        for (int k = 0; k < PE_SIZE; k++) begin
            row_en[PE_SIZE-1-k] = skew_q[k];
        end
    end

    // Enable delay line; keeps shifting through DRAIN/DONE so late lanes
    // finish, and is flushed by abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            weight_en_q <= 1'b0;
            skew_q      <= '0;
        end else if (abort_i) begin
            weight_en_q <= 1'b0;
            skew_q      <= '0;
        end else begin
            weight_en_q <= weight_rd_en_q;
            skew_q      <= skew_d;
        end
    end

`ifdef SA_CTRL_PERF_EN
    logic [31:0] perf_cnt_q;
    logic [31:0] perf_cycles_q;

    // Busy-cycle counter; the DONE cycle itself is included in the
    // latched value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cnt_q    <= '0;
            perf_cycles_q <= '0;
        end else if (abort_i) begin
            perf_cnt_q <= '0;
        end else if (state_q == ST_IDLE && start_i) begin
            perf_cnt_q <= '0;
        end else if (busy_q) begin
            perf_cnt_q <= perf_cnt_q + 32'd1;
            if (state_q == ST_DONE) begin
                perf_cycles_q <= perf_cnt_q + 32'd1;
            end
        end
    end

    assign perf_cycles_o = perf_cycles_q;
`endif

    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign weight_rd_en_o   = weight_rd_en_q;
    assign weight_rd_addr_o = weight_rd_addr_q;
    assign ifmap_rd_en_o    = ifmap_rd_en_q;
    assign ifmap_rd_addr_o  = ifmap_rd_addr_q;
    assign weight_en_col_o  = {PE_SIZE{weight_en_q}};
    assign ifmap_en_row_o   = row_en;
    assign psum_en_row_o    = row_en;

endmodule
